// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle right shifter (SRL/SRA/SRLV/SRAV) with a start/done handshake.
// It shifts one bit position per clock. With SHIFT_RIGHT_SEQ_FAST_EN defined, it shifts four
// positions per clock while at least four remain.
//
// Parameters:
//   width       - operand/result width (>= 2)
//   shamt_width - shift-amount width; the maximum shift is 2**shamt_width - 1
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   start   - request a shift; sampled only in IDLE or DONE
//   in      - operand, captured on the accepting edge
//   shamt   - shift amount, captured on the accepting edge
//   arith   - 1 = sign-fill, 0 = zero-fill; captured on the accepting edge
//   busy    - high while shifting
//   done    - one-cycle completion pulse
//   out     - result register; holds its value until the next accepted start
module shift_right_seq #(
    parameter int unsigned width       = 32,
    parameter int unsigned shamt_width = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [width-1:0]       in,
    input  logic [shamt_width-1:0] shamt,
    input  logic                   arith,
    output logic                   busy,
    output logic                   done,
    output logic [width-1:0]       out
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [width-1:0]       acc_q, acc_d;
    logic [shamt_width-1:0] cnt_q, cnt_d;
    logic                   fill_q, fill_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    acc_d   = in;
                    cnt_d   = shamt;
                    fill_d  = arith & in[width-1];
                    state_d = (shamt != '0) ? StShift : StDone;
                end else begin
                    state_d = StIdle;
                end
            end

            StShift: begin
`ifdef SHIFT_RIGHT_SEQ_FAST_EN
                if (int'(cnt_q) >= 4) begin
                    // Mask of the top four bits (all bits when width < 4).
                    acc_d = (acc_q >> 4) | (fill_q ? ~({width{1'b1}} >> 4) : '0);
                    cnt_d = cnt_q - shamt_width'(4);
                end else begin
                    acc_d = {fill_q, acc_q[width-1:1]};
                    cnt_d = cnt_q - shamt_width'(1);
                end
`else
                acc_d = {fill_q, acc_q[width-1:1]};
                cnt_d = cnt_q - shamt_width'(1);
`endif
                if (cnt_d == '0) begin
                    state_d = StDone;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign out  = acc_q;

endmodule

// File: tb/tb_shift_right_seq.sv
module tb_shift_right_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] in_v;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] out_v;

    logic        start2;
    logic [27:0] in2;
    logic [4:0]  shamt2;
    logic        arith2;
    logic        busy2;
    logic        done2;
    logic [27:0] out2;

    int checks = 0;
    int errors = 0;

`ifdef SHIFT_RIGHT_SEQ_FAST_EN
    localparam int Edges31 = 10;
`else
    localparam int Edges31 = 31;
`endif

    shift_right_seq #(.width(32), .shamt_width(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .in      (in_v),
        .shamt   (shamt),
        .arith   (arith),
        .busy    (busy),
        .done    (done),
        .out     (out_v)
    );

    shift_right_seq #(.width(28), .shamt_width(5)) dut28 (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start2),
        .in      (in2),
        .shamt   (shamt2),
        .arith   (arith2),
        .busy    (busy2),
        .done    (done2),
        .out     (out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller is 1 time unit after a rising edge. Returns with done observed high,
    // again 1 unit after an edge. edges = edges after the accepting edge until done.
    task automatic run_op(input logic [31:0] a, input logic [4:0] n, input logic ar,
                          output int edges, output int busy_cycles, output int overlap,
                          output bit timed_out);
        start = 1'b1; in_v = a; shamt = n; arith = ar;
        @(posedge clk); #1;
        start = 1'b0; in_v = 32'hDEAD_BEEF; shamt = 5'd7; arith = ~ar;
        edges = 0; busy_cycles = 0; overlap = 0; timed_out = 0;
        while (!done && edges < 100) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            edges++;
        end
        if (busy && done) overlap++;
        if (!done) timed_out = 1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; in_v = '0; shamt = '0; arith = 1'b0;
        start2 = 1'b0; in2 = '0; shamt2 = '0; arith2 = 1'b0;
        #23;
        checks++;
        if (out_v !== 32'h0) begin errors++; $display("FAIL reset_out got %h want %h", out_v, 32'h0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                if (done || busy) seen++;
                @(posedge clk); #1;
            end
            checks++;
            if (seen !== 0) begin errors++; $display("FAIL idle_no_done got %0d active cycles want 0", seen); end
        end
    endtask

    task automatic test_shift_4(input logic ar, input logic [31:0] exp);
        int e, b, ov; bit to;
        run_op(32'h8000_0000, 5'd4, ar, e, b, ov, to);
        checks++;
        if (to) begin errors++; $display("FAIL shift4_timeout arith=%b no done", ar); end
        checks++;
        if (out_v !== exp) begin errors++; $display("FAIL shift4_out arith=%b got %h want %h", ar, out_v, exp); end
`ifndef SHIFT_RIGHT_SEQ_FAST_EN
        checks++;
        if (e !== 4) begin errors++; $display("FAIL shift4_latency got %0d want 4", e); end
        checks++;
        if (b !== 4) begin errors++; $display("FAIL shift4_busy got %0d want 4", b); end
`endif
        checks++;
        if (ov !== 0) begin errors++; $display("FAIL shift4_overlap busy and done both high"); end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL shift4_done_pulse got done=%b busy=%b want 0 0", done, busy);
        end
        checks++;
        if (out_v !== exp) begin errors++; $display("FAIL shift4_hold got %h want %h", out_v, exp); end
    endtask

    task automatic test_edge_amounts;
        int e, b, ov; bit to;
        run_op(32'h1234_5678, 5'd0, 1'b1, e, b, ov, to);
        checks++;
        if (out_v !== 32'h1234_5678) begin errors++; $display("FAIL shamt0_out got %h want %h", out_v, 32'h1234_5678); end
        checks++;
        if (e !== 0) begin errors++; $display("FAIL shamt0_latency got %0d want 0", e); end
        checks++;
        if (b !== 0) begin errors++; $display("FAIL shamt0_busy got %0d want 0", b); end
        @(posedge clk); #1;
        run_op(32'h8000_0000, 5'd31, 1'b1, e, b, ov, to);
        checks++;
        if (out_v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL shamt31_out got %h want %h", out_v, 32'hFFFF_FFFF); end
        checks++;
        if (e !== Edges31) begin errors++; $display("FAIL shamt31_latency got %0d want %0d", e, Edges31); end
        checks++;
        if (b !== Edges31) begin errors++; $display("FAIL shamt31_busy got %0d want %0d", b, Edges31); end
        @(posedge clk); #1;
        // Logical 31 of a negative operand leaves just the LSB.
        run_op(32'h8000_0000, 5'd31, 1'b0, e, b, ov, to);
        checks++;
        if (out_v !== 32'h1) begin errors++; $display("FAIL srl31_out got %h want %h", out_v, 32'h1); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int e;
        start = 1'b1; in_v = 32'hFFFF_FFFF; shamt = 5'd8; arith = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; in_v = 32'h0; shamt = 5'd3; arith = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e = 2;
        while (!done && e < 100) begin
            @(posedge clk); #1;
            e++;
        end
        checks++;
        if (out_v !== 32'h00FF_FFFF) begin errors++; $display("FAIL ignore_out got %h want %h", out_v, 32'h00FF_FFFF); end
        checks++;
        if (e !== Edges31 - Edges31 + ((Edges31 == 10) ? 2 : 8)) begin
            errors++; $display("FAIL ignore_latency got %0d edges", e);
        end
        // Hold start through the done cycle.
        start = 1'b1; in_v = 32'h2; shamt = 5'd1; arith = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done); end
        checks++;
        if (out_v !== 32'h1) begin errors++; $display("FAIL b2b_out got %h want %h", out_v, 32'h1); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int seen;
        start = 1'b1; in_v = 32'hFFFF_0000; shamt = 5'd20; arith = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_v !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got out=%h busy=%b done=%b want 0 0 0", out_v, busy, done);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (done || busy) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midreset_no_done got %0d active cycles want 0", seen); end
    endtask

    task automatic test_param;
        int e;
        logic [27:0] vin [2];
        logic [27:0] vexp [2];
        vin[0] = 28'd40;        vexp[0] = 28'd10;
        vin[1] = 28'hFFFFFFC;   vexp[1] = 28'h3FFFFFF;
        for (int k = 0; k < 2; k++) begin
            start2 = 1'b1; in2 = vin[k]; shamt2 = 5'd2; arith2 = 1'b0;
            @(posedge clk); #1;
            start2 = 1'b0;
            e = 0;
            while (!done2 && e < 100) begin
                @(posedge clk); #1;
                e++;
            end
            checks++;
            if (out2 !== vexp[k]) begin errors++; $display("FAIL param28_out[%0d] got %h want %h", k, out2, vexp[k]); end
            checks++;
            if (e !== 2) begin errors++; $display("FAIL param28_latency[%0d] got %0d want 2", k, e); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_shift_4(1'b0, 32'h0800_0000);
        test_shift_4(1'b1, 32'hF800_0000);
        test_edge_amounts();
        test_back_to_back();
        test_reset_mid();
        test_param();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
